// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM port arbiter: default widths, FSM state
// encoding, write-buffer depth and the idle levels of the SRAM control pins.
package sram_pkg;

  localparam int unsigned ADDR_W_DEF  = 18;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned WRBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRd     = 2'd1,
    StWr     = 2'd2,
    StWrHold = 2'd3
  } arb_state_e;

  // Active-low strobes: deasserted level, and chip-enable level while in reset
  localparam logic SRAM_STROBE_IDLE = 1'b1;
  localparam logic SRAM_CE_N_RESET  = 1'b1;
  localparam logic SRAM_CE_N_ACTIVE = 1'b0;

endpackage

// File: rtl/sram_wr_fifo.sv
// Four-entry write buffer for the SRAM arbiter. Holds (address, data) pairs in
// arrival order and exposes an associative lookup that returns the newest
// buffered data for a given address, so reads never observe stale SRAM words.
module sram_wr_fifo
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              empty_o,
  output logic              full_o,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o
);

  localparam int unsigned Depth = WRBUF_DEPTH;
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = PtrW + 1;

  logic [ADDR_W-1:0] addr_q [Depth];
  logic [DATA_W-1:0] data_q [Depth];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CntW'(Depth));
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  // Pointer/occupancy next state; push on full and pop on empty are ignored
  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are qualified by count_q so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Scan oldest to newest so the last (newest) matching entry wins
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if ((CntW'(i) < count_q) && (addr_q[rd_ptr_q + PtrW'(i)] == lookup_addr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[rd_ptr_q + PtrW'(i)];
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of an asynchronous SRAM: a read port (display) and
// a write port (renderer). Reads have priority, bounded by a starvation counter
// that forces a write grant after WR_STARVE_MAX consecutive reads while a write
// waits. Optional macro SRAM_ARB_WRBUF_EN adds a 4-entry write buffer with
// read-after-write forwarding.
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned WR_STARVE_MAX = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  localparam int unsigned     CntW      = $clog2(WR_STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(WR_STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              ce_n_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_data_valid_q, rd_data_valid_d;

  logic              wr_pending;
  logic [ADDR_W-1:0] wr_src_addr;
  logic [DATA_W-1:0] wr_src_data;
  logic [DATA_W-1:0] rd_capture;
  logic              starve_hit, rd_fire, wr_grant;

`ifdef SRAM_ARB_WRBUF_EN
  logic              fifo_empty, fifo_full, fifo_push;
  logic              fwd_hit_q, fwd_hit_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  assign wr_ready   = !reset && !fifo_full;
  assign fifo_push  = wr_valid && wr_ready;
  assign wr_pending = !fifo_empty;

  sram_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_fifo (
    .clk_i         (CLOCK_50),
    .rst_i         (reset),
    .push_i        (fifo_push),
    .push_addr_i   (wr_addr),
    .push_data_i   (wr_data),
    .pop_i         (wr_grant),
    .head_addr_o   (wr_src_addr),
    .head_data_o   (wr_src_data),
    .empty_o       (fifo_empty),
    .full_o        (fifo_full),
    .lookup_addr_i (rd_addr),
    .fwd_hit_o     (fwd_hit_d),
    .fwd_data_o    (fwd_data_d)
  );

  // Latch the lookup result each cycle; in RD it holds the accept-cycle match
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign rd_capture = fwd_hit_q ? fwd_data_q : SRAM_DQ;
`else
  assign wr_ready    = !reset && (state_q == StIdle) && !rd_fire;
  assign wr_pending  = wr_valid;
  assign wr_src_addr = wr_addr;
  assign wr_src_data = wr_data;
  assign rd_capture  = SRAM_DQ;
`endif

  // Arbitration: read priority unless the starvation limit has been reached
  always_comb begin
    starve_hit = (starve_q >= StarveMax) && wr_pending;
    rd_ready   = !reset && (state_q == StIdle) && !starve_hit;
    rd_fire    = rd_valid && rd_ready;
    wr_grant   = !reset && (state_q == StIdle) && wr_pending && !rd_fire;
    starve_d   = starve_q;
    if (wr_grant) begin
      starve_d = '0;
    end else if (rd_fire && wr_pending && (starve_q < StarveMax)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // FSM state register plus all registered SRAM pins and read response
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q         <= StIdle;
      starve_q        <= '0;
      addr_q          <= '0;
      dq_out_q        <= '0;
      dq_oe_q         <= 1'b0;
      we_n_q          <= SRAM_STROBE_IDLE;
      oe_n_q          <= SRAM_STROBE_IDLE;
      ce_n_q          <= SRAM_CE_N_RESET;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      starve_q        <= starve_d;
      addr_q          <= addr_d;
      dq_out_q        <= dq_out_d;
      dq_oe_q         <= dq_oe_d;
      we_n_q          <= we_n_d;
      oe_n_q          <= oe_n_d;
      ce_n_q          <= SRAM_CE_N_ACTIVE;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
    end
  end

  // Next state: every non-idle state lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rd_fire) begin
          state_d = StRd;
        end else if (wr_grant) begin
          state_d = StWr;
        end
      end
      StRd:     state_d = StIdle;
      StWr:     state_d = StWrHold;
      StWrHold: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Pin values for the next cycle, read capture and response pulse
  always_comb begin
    addr_d          = addr_q;
    dq_out_d        = dq_out_q;
    dq_oe_d         = 1'b0;
    we_n_d          = SRAM_STROBE_IDLE;
    oe_n_d          = SRAM_STROBE_IDLE;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_fire) begin
          addr_d = rd_addr;
          oe_n_d = 1'b0;
        end else if (wr_grant) begin
          addr_d   = wr_src_addr;
          dq_out_d = wr_src_data;
          dq_oe_d  = 1'b1;
          we_n_d   = 1'b0;
        end
      end
      StRd: begin
        rd_data_d       = rd_capture;
        rd_data_valid_d = 1'b1;
      end
      // WE_N rises with address and data still stable for hold time
      StWr:     dq_oe_d = 1'b1;
      StWrHold: dq_oe_d = 1'b0;
      default: ;
    endcase
  end

  assign SRAM_DQ       = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};
  assign SRAM_ADDR     = addr_q;
  assign SRAM_WE_N     = we_n_q;
  assign SRAM_OE_N     = oe_n_q;
  assign SRAM_CE_N     = ce_n_q;
  assign SRAM_UB_N     = ce_n_q;
  assign SRAM_LB_N     = ce_n_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;

  // Bus safety: no drive while the SRAM outputs, write strobe only in WR
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      assert (!(dq_oe_q && !oe_n_q));
      assert (we_n_q || (state_q == StWr));
    end
  end

endmodule
